// File: rtl/sysid_if.sv
// sysid_if: Avalon-MM read-only link between the checker and a system ID slave.
interface sysid_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    modport master (output avm_address, avm_read, input avm_readdata, avm_waitrequest);
    modport slave  (input avm_address, avm_read, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/sysid_checker.sv
// sysid_checker: reads the system ID (and timestamp when SYSID_CHECK_TS_EN is defined)
// from an Avalon-MM slave and compares them against expected values, with a per-read stall timeout.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h5748B343,
    parameter logic [31:0] EXPECTED_TS    = 32'h0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    sysid_if.master     avm,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout
);
`ifdef SYSID_CHECK_TS_EN
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD_ID, FIN} state_t;
    wire unused_ts = ^EXPECTED_TS;
`endif
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t      state;
    logic [15:0] wait_cnt;
    logic        expired;
    // the stall cycle that would bring the counter to TIMEOUT_CYCLES ends the read
    assign expired = avm.avm_waitrequest && wait_cnt == LAST;
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            avm.avm_read    <= 1'b0;
            avm.avm_address <= 1'b0;
            id_value        <= '0;
            ts_value        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            id_match        <= 1'b0;
            ts_match        <= 1'b0;
            timeout         <= 1'b0;
            wait_cnt        <= '0;
        end else begin
            case (state)
                IDLE, FIN: if (start) begin
                    state           <= RD_ID;
                    avm.avm_read    <= 1'b1;
                    avm.avm_address <= 1'b0;
                    busy            <= 1'b1;
                    done            <= 1'b0;
                    id_match        <= 1'b0;
                    ts_match        <= 1'b0;
                    timeout         <= 1'b0;
                    id_value        <= '0;
                    ts_value        <= '0;
                    wait_cnt        <= '0;
                end
                RD_ID: if (!avm.avm_waitrequest) begin
                    id_value <= avm.avm_readdata;
                    wait_cnt <= '0;
`ifdef SYSID_CHECK_TS_EN
                    state           <= RD_TS;
                    avm.avm_address <= 1'b1;
`else
                    state        <= FIN;
                    avm.avm_read <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    id_match     <= avm.avm_readdata == EXPECTED_ID;
                    ts_match     <= 1'b1;
`endif
                end else if (expired) begin
                    state        <= FIN;
                    avm.avm_read <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    timeout      <= 1'b1;
                    wait_cnt     <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
`ifdef SYSID_CHECK_TS_EN
                RD_TS: if (!avm.avm_waitrequest) begin
                    state        <= FIN;
                    ts_value     <= avm.avm_readdata;
                    avm.avm_read <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    id_match     <= id_value == EXPECTED_ID;
                    ts_match     <= avm.avm_readdata == EXPECTED_TS;
                    wait_cnt     <= '0;
                end else if (expired) begin
                    state        <= FIN;
                    avm.avm_read <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    timeout      <= 1'b1;
                    wait_cnt     <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h5748B343: system ID value the checker expects at slave word 0.
REQ-002 Parameter EXPECTED_TS, default 32'h0: timestamp value the checker expects at slave word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535: maximum consecutive waitrequest cycles tolerated per read.
REQ-004 clock  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a check sequence.
REQ-007 avm_address  out  1  Avalon-MM word address to the system ID slave (0 = ID, 1 = timestamp).
REQ-008 avm_read  out  1  Avalon-MM read strobe.
REQ-009 avm_readdata  in  32  read data from the slave, valid in any cycle where avm_read=1 and avm_waitrequest=0.
REQ-010 avm_waitrequest  in  1  slave stall; tie 0 for zero-wait slaves.
REQ-011 id_value  out  32  captured word 0.
REQ-012 ts_value  out  32  captured word 1.
REQ-013 busy  out  1  sequence in progress.
REQ-014 done  out  1  sequence finished; held until next accepted start or reset.
REQ-015 id_match  out  1  id_value == EXPECTED_ID; valid while done=1.
REQ-016 ts_match  out  1  ts_value == EXPECTED_TS; valid while done=1.
REQ-017 timeout  out  1  a read exceeded TIMEOUT_CYCLES; valid while done=1.

Function
REQ-018 FSM states IDLE, RD_ID, RD_TS, FIN; all outputs registered.
REQ-019 IDLE or FIN with start=1 -> RD_ID next cycle; done, id_match, ts_match, timeout, id_value, ts_value cleared in that same edge.
REQ-020 start in RD_ID or RD_TS is ignored.
REQ-021 RD_ID: avm_read=1, avm_address=0; on a cycle with avm_waitrequest=0, id_value <= avm_readdata and -> RD_TS.
REQ-022 RD_TS: avm_read=1, avm_address=1; on a cycle with avm_waitrequest=0, ts_value <= avm_readdata and -> FIN.
REQ-023 avm_address and avm_read stay stable while avm_waitrequest=1.
REQ-024 FIN: avm_read=0, done=1, busy=0; id_match and ts_match computed from captured values on entry.
REQ-025 busy=1 exactly in RD_ID and RD_TS.
REQ-026 Latency with zero wait states: start sampled at edge N -> avm_read high from cycle N+1, done high from cycle N+3.
REQ-027 Wait counter (16 bit) clears on each state entry; increments each cycle avm_waitrequest=1 in RD_ID/RD_TS.
REQ-028 Counter reaching TIMEOUT_CYCLES while waitrequest=1 -> FIN with timeout=1, id_match=0, ts_match=0, avm_read=0 next cycle; uncaptured value stays 0.
REQ-029 waitrequest dropping in the same cycle the counter would reach TIMEOUT_CYCLES counts as a successful read, not a timeout.

Reset
REQ-030 reset=1 at any edge, including mid-read, forces IDLE; avm_read=0, avm_address=0, id_value=0, ts_value=0, busy=0, done=0, id_match=0, ts_match=0, timeout=0, counter=0.
REQ-031 reset has priority over start.

Configuration
REQ-032 Macro SYSID_CHECK_TS_EN defined: full ID-then-timestamp sequence as above.
REQ-033 SYSID_CHECK_TS_EN undefined: RD_TS state absent; RD_ID success -> FIN; ts_value fixed 0; ts_match=1 whenever done=1 and timeout=0; zero-wait latency start edge N -> done at N+2.

Verification
REQ-034 waitrequest=0, slave returns 32'h5748B343 at addr 0, 32'h0 at addr 1, start pulse -> done at N+3, id_match=1, ts_match=1, timeout=0.
REQ-035 Slave returns 32'h12345678 at addr 0 -> done=1, id_match=0, id_value=32'h12345678.
REQ-036 TIMEOUT_CYCLES=4, waitrequest stuck 1 -> avm_read high exactly 4 cycles then FIN, timeout=1, both match flags 0.
REQ-037 waitrequest=1 for 3 cycles on addr 1, TIMEOUT_CYCLES=4 -> address held 1, read completes, timeout=0, done=1.
REQ-038 reset asserted during RD_TS -> next cycle all outputs 0, state IDLE; subsequent start runs a clean sequence.
REQ-039 SYSID_CHECK_TS_EN undefined, zero wait -> single read at addr 0, done at N+2, ts_match=1.
